// File: rtl/apb_slave_mem.sv
// APB completer with a byte-wide register-file memory and programmable PREADY wait states.
// Flags PSLVERR for out-of-range addresses, missing setup phases and signals changed mid-transfer.
module apb_slave_mem #(
  parameter int ADDR_W      = 8,
  parameter int DATA_W      = 8,
  parameter int DEPTH       = 64,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              PCLK,
  input  logic              PRESETn,
  input  logic              PSEL,
  input  logic              PENABLE,
  input  logic              PWRITE,
  input  logic [8:0]        PADDR,
  input  logic [DATA_W-1:0] PWDATA,
  output logic [DATA_W-1:0] PRDATA,
  output logic              PREADY,
  output logic              PSLVERR
);

  localparam int IDX_W = (DEPTH < 2) ? 1 : $clog2(DEPTH);
  localparam int CNT_W = (WAIT_CYCLES < 2) ? 1 : $clog2(WAIT_CYCLES + 1);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_READY} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              write_q, write_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              err_q, err_d;
  logic              pready_q, pready_d;
  logic              pslverr_q, pslverr_d;
  logic [DATA_W-1:0] prdata_q, prdata_d;
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];

  logic [ADDR_W-1:0] paddr_dec;
  logic              access;
  logic              mismatch;
  logic              unused_paddr;

  assign paddr_dec    = PADDR[ADDR_W-1:0];
  assign access       = PSEL & PENABLE;
  // PADDR[8] selects between the two instances upstream
  assign unused_paddr = ^PADDR[8:ADDR_W];

  // Master must hold address, direction and (for writes) data steady for the whole transfer
  assign mismatch = (paddr_dec != addr_q) | (PWRITE != write_q) |
                    (write_q & (PWDATA != wdata_q));

  function automatic logic out_of_range(input logic [ADDR_W-1:0] a);
    return 32'(a) >= 32'(DEPTH);
  endfunction

  function automatic logic [IDX_W-1:0] idx(input logic [ADDR_W-1:0] a);
    return a[IDX_W-1:0];
  endfunction

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    write_d   = write_q;
    wdata_d   = wdata_q;
    cnt_d     = cnt_q;
    err_d     = err_q;
    pready_d  = pready_q;
    pslverr_d = pslverr_q;
    prdata_d  = prdata_q;
    mem_d     = mem_q;
    case (state_q)
      S_IDLE: begin
        if (PSEL && !PENABLE) begin
          addr_d  = paddr_dec;
          write_d = PWRITE;
          wdata_d = PWDATA;
          cnt_d   = CNT_W'(WAIT_CYCLES);
          if (WAIT_CYCLES == 0) begin
            // Zero-wait: latched values equal the bus, so only the range check applies
            state_d   = S_READY;
            err_d     = out_of_range(paddr_dec);
            pready_d  = 1'b1;
            pslverr_d = err_d;
            prdata_d  = (!PWRITE && !err_d) ? mem_q[idx(paddr_dec)] : '0;
          end else begin
            state_d = S_WAIT;
          end
        end else if (access) begin
          state_d   = S_READY;
          err_d     = 1'b1;
          pready_d  = 1'b1;
          pslverr_d = 1'b1;
          prdata_d  = '0;
        end
      end
      S_WAIT: begin
        if (access) begin
          if (cnt_q == CNT_W'(1)) begin
            state_d   = S_READY;
            err_d     = out_of_range(addr_q) | mismatch;
            pready_d  = 1'b1;
            pslverr_d = err_d;
            prdata_d  = (!write_q && !err_d) ? mem_q[idx(addr_q)] : '0;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_READY: begin
        // Writes commit only on a genuine completion edge of an error-free transfer
        if (access && write_q && !err_q) mem_d[idx(addr_q)] = wdata_q;
        state_d   = S_IDLE;
        err_d     = 1'b0;
        pready_d  = 1'b0;
        pslverr_d = 1'b0;
        prdata_d  = '0;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge PCLK) begin
    if (!PRESETn) begin
      state_q   <= S_IDLE;
      addr_q    <= '0;
      write_q   <= 1'b0;
      wdata_q   <= '0;
      cnt_q     <= '0;
      err_q     <= 1'b0;
      pready_q  <= 1'b0;
      pslverr_q <= 1'b0;
      prdata_q  <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      write_q   <= write_d;
      wdata_q   <= wdata_d;
      cnt_q     <= cnt_d;
      err_q     <= err_d;
      pready_q  <= pready_d;
      pslverr_q <= pslverr_d;
      prdata_q  <= prdata_d;
      mem_q     <= mem_d;
    end
  end

  assign PRDATA  = prdata_q;
  assign PREADY  = pready_q;
  assign PSLVERR = pslverr_q;

endmodule

// File: tb/tb_apb_slave_mem.sv
// Directed bench: a 2-wait-state instance (a) and a zero-wait instance (b) share one APB bus
// with separate selects, as the two completers do behind the master bridge.
module tb_apb_slave_mem;

  logic       PCLK = 1'b0;
  logic       PRESETn;
  logic       psel_a, psel_b, penable, pwrite;
  logic [8:0] paddr;
  logic [7:0] pwdata;
  logic [7:0] prdata_a, prdata_b;
  logic       pready_a, pready_b, pslverr_a, pslverr_b;

  int checks = 0;
  int errors = 0;

  always #5 PCLK = ~PCLK;

  apb_slave_mem #(.WAIT_CYCLES(2)) dut_a (
    .PCLK(PCLK), .PRESETn(PRESETn), .PSEL(psel_a), .PENABLE(penable), .PWRITE(pwrite),
    .PADDR(paddr), .PWDATA(pwdata), .PRDATA(prdata_a), .PREADY(pready_a), .PSLVERR(pslverr_a));

  apb_slave_mem #(.WAIT_CYCLES(0)) dut_b (
    .PCLK(PCLK), .PRESETn(PRESETn), .PSEL(psel_b), .PENABLE(penable), .PWRITE(pwrite),
    .PADDR(paddr), .PWDATA(pwdata), .PRDATA(prdata_b), .PREADY(pready_b), .PSLVERR(pslverr_b));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge PCLK);
    #1;
  endtask

  task automatic idle();
    psel_a = 1'b0; psel_b = 1'b0; penable = 1'b0;
  endtask

  // Full transfer on instance b (1) or a (0); nacc counts access cycles up to and including PREADY
  task automatic xfer(input bit b, input bit w, input logic [8:0] a, input logic [7:0] d,
                      output logic [7:0] rd, output logic err, output int nacc);
    logic rdy;
    psel_a = !b; psel_b = b; penable = 1'b0; pwrite = w; paddr = a; pwdata = d;
    cyc();
    penable = 1'b1;
    nacc = 1;
    rdy = b ? pready_b : pready_a;
    while (!rdy && nacc < 20) begin
      cyc();
      nacc++;
      rdy = b ? pready_b : pready_a;
    end
    chk("ready_seen", {31'd0, rdy}, 32'd1);
    rd  = b ? prdata_b : prdata_a;
    err = b ? pslverr_b : pslverr_a;
    cyc();
    idle();
  endtask

  logic [7:0] rd;
  logic       err;
  int         n;

  initial begin
    idle();
    pwrite = 1'b0; paddr = '0; pwdata = '0;
    PRESETn = 1'b0;
    cyc(); cyc();
    PRESETn = 1'b1;
    chk("rst_pready_a", {31'd0, pready_a}, 32'd0);
    chk("rst_pslverr_a", {31'd0, pslverr_a}, 32'd0);
    chk("rst_prdata_a", {24'd0, prdata_a}, 32'd0);
    chk("rst_pready_b", {31'd0, pready_b}, 32'd0);

    // 1: two wait states
    xfer(0, 1, 9'h010, 8'hA5, rd, err, n);
    chk("t1_wr_nacc", n, 32'd3);
    chk("t1_wr_err", {31'd0, err}, 32'd0);
    chk("t1_pready_cleared", {31'd0, pready_a}, 32'd0);
    xfer(0, 0, 9'h010, 8'h00, rd, err, n);
    chk("t1_rd_nacc", n, 32'd3);
    chk("t1_rd_data", {24'd0, rd}, 32'hA5);
    chk("t1_rd_err", {31'd0, err}, 32'd0);

    // 2: zero-wait, back-to-back, PADDR[8] ignored
    xfer(1, 1, 9'h105, 8'h3C, rd, err, n);
    chk("t2_wr_nacc", n, 32'd1);
    chk("t2_wr_err", {31'd0, err}, 32'd0);
    xfer(1, 0, 9'h005, 8'h00, rd, err, n);
    chk("t2_rd_nacc", n, 32'd1);
    chk("t2_rd_data", {24'd0, rd}, 32'h3C);
    xfer(1, 1, 9'h050, 8'hEE, rd, err, n);
    chk("t2_oor_err", {31'd0, err}, 32'd1);

    // 3: out of range
    xfer(0, 1, 9'h050, 8'hFF, rd, err, n);
    chk("t3_wr_err", {31'd0, err}, 32'd1);
    xfer(0, 0, 9'h050, 8'h00, rd, err, n);
    chk("t3_rd_err", {31'd0, err}, 32'd1);
    chk("t3_rd_data", {24'd0, rd}, 32'h00);
    xfer(0, 0, 9'h03F, 8'h00, rd, err, n);
    chk("t3_last_err", {31'd0, err}, 32'd0);
    chk("t3_last_data", {24'd0, rd}, 32'h00);

    // 4: master abort during wait
    xfer(0, 1, 9'h020, 8'h11, rd, err, n);
    psel_a = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 9'h020; pwdata = 8'h22;
    cyc();
    penable = 1'b1;
    chk("t4_acc1_pready", {31'd0, pready_a}, 32'd0);
    cyc();
    chk("t4_acc2_pready", {31'd0, pready_a}, 32'd0);
    idle();
    cyc();
    chk("t4_abort_pready", {31'd0, pready_a}, 32'd0);
    cyc();
    chk("t4_abort_pready2", {31'd0, pready_a}, 32'd0);
    xfer(0, 0, 9'h020, 8'h00, rd, err, n);
    chk("t4_rd_data", {24'd0, rd}, 32'h11);

    // 5a: access phase with no setup
    psel_a = 1'b1; penable = 1'b1; pwrite = 1'b1; paddr = 9'h020; pwdata = 8'h99;
    cyc();
    chk("t5a_pready", {31'd0, pready_a}, 32'd1);
    chk("t5a_pslverr", {31'd0, pslverr_a}, 32'd1);
    chk("t5a_prdata", {24'd0, prdata_a}, 32'h00);
    cyc();
    idle();
    xfer(0, 0, 9'h020, 8'h00, rd, err, n);
    chk("t5a_mem_kept", {24'd0, rd}, 32'h11);

    // 5b: address changed during wait
    psel_a = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 9'h010; pwdata = 8'h55;
    cyc();
    penable = 1'b1; paddr = 9'h011;
    cyc();
    chk("t5b_acc2_pready", {31'd0, pready_a}, 32'd0);
    cyc();
    chk("t5b_pready", {31'd0, pready_a}, 32'd1);
    chk("t5b_pslverr", {31'd0, pslverr_a}, 32'd1);
    cyc();
    idle();
    xfer(0, 0, 9'h010, 8'h00, rd, err, n);
    chk("t5b_mem10", {24'd0, rd}, 32'hA5);
    xfer(0, 0, 9'h011, 8'h00, rd, err, n);
    chk("t5b_mem11", {24'd0, rd}, 32'h00);

    // 6: reset during wait
    psel_a = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 9'h008; pwdata = 8'h77;
    cyc();
    penable = 1'b1;
    cyc();
    PRESETn = 1'b0;
    cyc();
    PRESETn = 1'b1;
    idle();
    chk("t6_pready", {31'd0, pready_a}, 32'd0);
    chk("t6_pslverr", {31'd0, pslverr_a}, 32'd0);
    chk("t6_prdata", {24'd0, prdata_a}, 32'h00);
    cyc();
    xfer(0, 0, 9'h008, 8'h00, rd, err, n);
    chk("t6_mem08", {24'd0, rd}, 32'h00);
    xfer(0, 0, 9'h010, 8'h00, rd, err, n);
    chk("t6_mem10_cleared", {24'd0, rd}, 32'h00);
    xfer(1, 0, 9'h005, 8'h00, rd, err, n);
    chk("t6_b_mem05_cleared", {24'd0, rd}, 32'h00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
